// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and pipeline-control unit for a five-stage RISC-V core. A private
// shadow of the ID/EX, EX/MEM and MEM/WB control fields is advanced with the
// same enables/flushes this unit drives. From that shadow the unit derives
// the stage enables, bubble insertion and EX-stage forwarding selects, and
// keeps saturating stall/flush counters.
//
// Parameters
//   REG_ADDR_W : register-index width
//   FWD_EN     : 1 = forwarding + load-use stall, 0 = stall on any RAW hazard
//   CNT_W      : performance-counter width
//
// Ports
//   clk, reset (async, active-low)
//   id_*              : decoded fields of the instruction held in IF/ID
//   ex_redirect       : taken branch/jump resolved in EX
//   dmem_ready        : data memory finishes the MEM-stage access this cycle
//   pc_en, ifid_en, idex_en, exmem_en : pipeline register load enables
//   ifid_flush, idex_flush            : bubble insertion into IF/ID, ID/EX
//   memwb_bubble      : MEM/WB entry written this cycle is invalid
//   fwd_a, fwd_b      : 00 = ID/EX value, 10 = EX/MEM result, 01 = MEM/WB result
//   stall_cycles      : saturating count of cycles with pc_en = 0
//   flush_count       : saturating count of redirect flushes
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter bit FWD_EN     = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  id_memacc,
  input  logic                  ex_redirect,
  input  logic                  dmem_ready,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  memwb_bubble,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
    logic                  memacc;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
  } stage_t;

  localparam int                    STAGE_W  = 4 + 3 * REG_ADDR_W;
  localparam stage_t                BUBBLE   = stage_t'({STAGE_W{1'b0}});
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1'b1);

  // A stage produces register r: valid, writes, not x0, and the index matches.
  function automatic logic writes_to(input stage_t s, input logic [REG_ADDR_W-1:0] r);
    writes_to = s.valid & s.regwrite & (s.rd != REG_ZERO) & (s.rd == r);
  endfunction

  // Youngest producer wins; a load still in EX/MEM has no result yet, so it
  // is skipped (load-use stalling guarantees it is consumed from MEM/WB).
  function automatic logic [1:0] fwd_select(input stage_t ex_s, input stage_t mem_s,
                                            input logic [REG_ADDR_W-1:0] r);
    logic [1:0] sel;
    if (writes_to(ex_s, r) && !ex_s.memread) begin
      sel = 2'b10;
    end else if (writes_to(mem_s, r)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  stage_t           idex_r, exmem_r, memwb_r;
  stage_t           id_stage_s, idex_nxt_s, exmem_nxt_s, memwb_nxt_s;
  logic             src1_s, src2_s;
  logic             mem_stall_s, redirect_s, load_use_s, raw_any_s;
  logic             data_haz_s, data_stall_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  // Shadow entry for the ID instruction. An unused source is recorded as x0,
  // which can never match a producer, so later stages need no use flags.
  always_comb begin
    id_stage_s = BUBBLE;
    if (id_valid) begin
      id_stage_s.valid    = 1'b1;
      id_stage_s.rd       = id_rd;
      id_stage_s.regwrite = id_regwrite;
      id_stage_s.memread  = id_memread;
      id_stage_s.memacc   = id_memacc;
      id_stage_s.rs1      = id_use_rs1 ? id_rs1 : REG_ZERO;
      id_stage_s.rs2      = id_use_rs2 ? id_rs2 : REG_ZERO;
    end else begin
      id_stage_s = BUBBLE;
    end
  end

  // Hazard detection and priority: memory stall > redirect > data stall.
  always_comb begin
    src1_s      = id_valid & id_use_rs1;
    src2_s      = id_valid & id_use_rs2;
    mem_stall_s = exmem_r.valid & exmem_r.memacc & ~dmem_ready;
    redirect_s  = ex_redirect & ~mem_stall_s;
    load_use_s  = idex_r.memread &
                  ((src1_s & writes_to(idex_r, id_rs1)) |
                   (src2_s & writes_to(idex_r, id_rs2)));
    // Without write-through, a MEM/WB producer must also be waited out.
    raw_any_s   = (src1_s & (writes_to(idex_r, id_rs1) | writes_to(exmem_r, id_rs1) |
                             writes_to(memwb_r, id_rs1))) |
                  (src2_s & (writes_to(idex_r, id_rs2) | writes_to(exmem_r, id_rs2) |
                             writes_to(memwb_r, id_rs2)));
    if (FWD_EN) begin
      data_haz_s = load_use_s;
    end else begin
      data_haz_s = raw_any_s;
    end
    data_stall_s = data_haz_s & ~mem_stall_s & ~redirect_s;
  end

  // Enables, flushes and forwarding selects.
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    if (FWD_EN) begin
      fwd_a = fwd_select(exmem_r, memwb_r, idex_r.rs1);
      fwd_b = fwd_select(exmem_r, memwb_r, idex_r.rs2);
    end else begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
    end
    if (mem_stall_s) begin
      // EX stays frozen, so a pending redirect is simply re-presented later.
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (redirect_s) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (data_stall_s) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else begin
      pc_en = 1'b1;
    end
  end

  // Next shadow contents, following the enables/flushes driven above.
  always_comb begin
    idex_nxt_s  = idex_r;
    exmem_nxt_s = exmem_r;
    memwb_nxt_s = memwb_r;
    if (mem_stall_s) begin
      memwb_nxt_s = BUBBLE;
    end else begin
      memwb_nxt_s = exmem_r;
      exmem_nxt_s = idex_r;
      if (idex_flush) begin
        idex_nxt_s = BUBBLE;
      end else begin
        idex_nxt_s = id_stage_s;
      end
    end
  end

  // Shadow pipeline registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idex_r  <= BUBBLE;
      exmem_r <= BUBBLE;
      memwb_r <= BUBBLE;
    end else begin
      idex_r  <= idex_nxt_s;
      exmem_r <= exmem_nxt_s;
      memwb_r <= memwb_nxt_s;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (!pc_en && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (redirect_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cycles = stall_cnt_r;
  assign flush_count  = flush_cnt_r;

endmodule
